// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives PLL reset, qualifies lock, retries, flags failure.
// Optional PLL_SUP_LOSS_RESET_EN: re-reset the PLL on lock loss in RUN.
module pll_lock_supervisor #(
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 500000,
  parameter int RST_PULSE_CYC    = 16,
  parameter int MAX_RETRY        = 7,
  parameter int CNT_W            = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       rst_out_n,
  output logic       locked,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

`ifdef PLL_SUP_LOSS_RESET_EN
  localparam state_t LOSS_NEXT = S_RESET;
`else
  localparam state_t LOSS_NEXT = S_WAIT;
`endif

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_d;
  logic [3:0]       retry_d;
  logic [7:0]       loss_d;
  logic             pll_rst_d;
  logic             run_d;
  logic             fail_d;
  logic             lock_m;
  logic             lock_s;

  // pll_lock is asynchronous; only lock_s is used below
  always_ff @(posedge sys_clk) begin
    lock_m <= pll_lock;
    lock_s <= lock_m;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state         <= S_RESET;
      timer         <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      rst_out_n     <= 1'b0;
      locked        <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state         <= state_d;
      timer         <= timer_d;
      retry_cnt     <= retry_d;
      lock_loss_cnt <= loss_d;
      pll_rst       <= pll_rst_d;
      rst_out_n     <= run_d;
      locked        <= run_d;
      fail          <= fail_d;
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer + 1'b1;
    retry_d = retry_cnt;
    loss_d  = lock_loss_cnt;
    unique case (state)
      S_RESET: begin
        if (timer == RST_LAST) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (lock_s) begin
          state_d = S_STABLE;
          timer_d = '0;
        end else if (timer == TO_LAST) begin
          timer_d = '0;
          if (retry_cnt == RETRY_MAX) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_cnt + 4'd1;
            state_d = S_RESET;
          end
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT;
          timer_d = '0;
        end else if (timer == STB_LAST) begin
          state_d = S_RUN;
          timer_d = '0;
          retry_d = '0;
        end
      end
      S_RUN: begin
        // timer idles here so it can never wrap
        timer_d = '0;
        if (!lock_s) begin
          state_d = LOSS_NEXT;
          if (lock_loss_cnt != 8'hFF) begin
            loss_d = lock_loss_cnt + 8'd1;
          end
        end
      end
      S_FAIL: begin
        timer_d = '0;
      end
      default: begin
        state_d = S_RESET;
        timer_d = '0;
      end
    endcase
  end

  // Outputs decode the next state so they register with it
  always_comb begin
    pll_rst_d = (state_d == S_RESET) || (state_d == S_FAIL);
    run_d     = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Random-stimulus bench for pll_lock_supervisor against a phase/countdown model.
// Build with or without PLL_SUP_LOSS_RESET_EN; the model follows the same macro.
module tb_pll_lock_supervisor;

  localparam int STB = 8;
  localparam int TO  = 64;
  localparam int RP  = 4;
  localparam int MR  = 2;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STB  = 2;
  localparam int P_RUN  = 3;
  localparam int P_FAIL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock = 1'b1;
  logic       pll_rst;
  logic       rst_out_n;
  logic       locked;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int failures = 0;

  int m_ph = P_RST;
  int m_left = RP;
  int m_retry = 0;
  int m_loss = 0;
  bit m_hist [2];

  pll_lock_supervisor #(
    .LOCK_STABLE_CYC (STB),
    .LOCK_TIMEOUT_CYC(TO),
    .RST_PULSE_CYC   (RP),
    .MAX_RETRY       (MR),
    .CNT_W           (20)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .pll_lock     (lock),
    .pll_rst      (pll_rst),
    .rst_out_n    (rst_out_n),
    .locked       (locked),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic enter(int ph);
    m_ph = ph;
    case (ph)
      P_RST:   m_left = RP;
      P_WAIT:  m_left = TO;
      P_STB:   m_left = STB;
      default: m_left = 0;
    endcase
  endtask

  // One clock edge of the supervisor, seen as phases with cycles left
  task automatic model_edge();
    bit ls;
    ls = m_hist[1];
    if (!rst_n) begin
      enter(P_RST);
      m_retry = 0;
      m_loss = 0;
    end else begin
      case (m_ph)
        P_RST: begin
          m_left--;
          if (m_left == 0) enter(P_WAIT);
        end
        P_WAIT: begin
          if (ls) enter(P_STB);
          else begin
            m_left--;
            if (m_left == 0) begin
              if (m_retry == MR) enter(P_FAIL);
              else begin
                m_retry++;
                enter(P_RST);
              end
            end
          end
        end
        P_STB: begin
          if (!ls) enter(P_WAIT);
          else begin
            m_left--;
            if (m_left == 0) begin
              enter(P_RUN);
              m_retry = 0;
            end
          end
        end
        P_RUN: begin
          if (!ls) begin
            if (m_loss < 255) m_loss++;
`ifdef PLL_SUP_LOSS_RESET_EN
            enter(P_RST);
`else
            enter(P_WAIT);
`endif
          end
        end
        default: ;
      endcase
    end
    m_hist[1] = m_hist[0];
    m_hist[0] = lock;
  endtask

  task automatic compare();
    chk("pll_rst", int'(pll_rst),
        int'(m_ph == P_RST || m_ph == P_FAIL));
    chk("rst_out_n", int'(rst_out_n), int'(m_ph == P_RUN));
    chk("locked", int'(locked), int'(m_ph == P_RUN));
    chk("fail", int'(fail), int'(m_ph == P_FAIL));
    chk("retry_cnt", int'(retry_cnt), m_retry);
    chk("lock_loss_cnt", int'(lock_loss_cnt), m_loss);
  endtask

  task automatic step(bit lk, bit rn);
    lock = lk;
    rst_n = rn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int dur;
    bit lv;
    repeat (3) step(1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b1);
    chk("first_lock", int'(locked), 1);

    repeat (2) step(1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b1);
    chk("glitch_loss", int'(lock_loss_cnt), 1);

    repeat (300) step(1'b0, 1'b1);
    chk("fail_set", int'(fail), 1);
    chk("fail_retry", int'(retry_cnt), MR);
    step(1'b0, 1'b0);
    chk("fail_clr", int'(fail), 0);

    repeat (400) begin
      lv = 1'($urandom_range(0, 1));
      dur = $urandom_range(1, 12);
      repeat (dur) step(lv, 1'b1);
      if ($urandom_range(0, 30) == 0) step(lv, 1'b0);
    end

    step(1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b1);
    repeat (270) begin
      dur = $urandom_range(1, 3);
      repeat (dur) step(1'b0, 1'b1);
      repeat (18) step(1'b1, 1'b1);
    end
    chk("loss_sat", int'(lock_loss_cnt), 255);
    chk("loss_run", int'(rst_out_n), 1);

    step(1'b1, 1'b0);
    chk("run_rst_out", int'(rst_out_n), 0);
    chk("run_rst_loss", int'(lock_loss_cnt), 0);
    repeat (5) step(1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
